// File: rtl/sqrt_fixed_pkg.sv
// Shared types and width helpers for the iterative fixed-point square root.
package sqrt_fixed_pkg;

    // Controller states; ROUND is only entered when rounding is built in.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Root width: half of the pre-shifted radicand width.
    function automatic int out_width(input int data_w, input int frac_w);
        return (data_w + frac_w) / 2;
    endfunction

    // Iteration counter width, never narrower than one bit.
    function automatic int cnt_width(input int out_w);
        return (out_w > 1) ? $clog2(out_w) : 1;
    endfunction

endpackage

// File: rtl/sqrt_fixed_step.sv
// One digit-by-digit square-root iteration: bring in two radicand bits,
// try to subtract {root,01}, and keep the difference if it did not go negative.
module sqrt_fixed_step #(
    parameter int OUT_W = 12
) (
    input  logic [OUT_W+1:0] rem,
    input  logic [OUT_W-1:0] root,
    input  logic [1:0]       pair,
    output logic [OUT_W+1:0] rem_next,
    output logic             root_bit
);

    logic [OUT_W+3:0] shifted;
    logic [OUT_W+3:0] trial_sub;
    logic [OUT_W+3:0] diff;

    // Trial subtraction done two bits wider so the comparison never wraps.
    always_comb begin
        shifted   = {rem, pair};
        trial_sub = {2'b00, root, 2'b01};
        diff      = shifted - trial_sub;
        root_bit  = (shifted >= trial_sub);
        rem_next  = root_bit ? (OUT_W+2)'(diff) : (OUT_W+2)'(shifted);
    end

endmodule

// File: rtl/sqrt_fixed_iter.sv
// Iterative unsigned fixed-point square root, one root bit per clock.
// Handshake: an operand is taken on a rising edge where i_valid && o_ready;
// a result is handed over on a rising edge where o_valid && i_ready, and
// o_data/o_rem stay frozen while o_valid is high and i_ready is low.
// Build option SQRT_FIXED_ROUND_EN adds a ROUND state for round-to-nearest.
module sqrt_fixed_iter
    import sqrt_fixed_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    localparam int OUT_W = out_width(DATA_W, FRAC_W)
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [OUT_W-1:0]  o_data,
    output logic [OUT_W:0]    o_rem,
    output logic              o_busy
);

    localparam int CNT_W = cnt_width(OUT_W);
    localparam int N_W   = 2 * OUT_W;

    state_t             state;
    state_t             state_nxt;
    logic [N_W-1:0]     n_sr;
    logic [OUT_W+1:0]   rem;
    logic [OUT_W-1:0]   root;
    logic [CNT_W-1:0]   cnt;
    logic [OUT_W+1:0]   rem_next;
    logic               root_bit;
    logic [OUT_W-1:0]   root_next;
    logic               accept;
    logic               last_iter;

    sqrt_fixed_step #(.OUT_W(OUT_W)) u_step (
        .rem      (rem),
        .root     (root),
        .pair     (n_sr[N_W-1 -: 2]),
        .rem_next (rem_next),
        .root_bit (root_bit)
    );

    assign root_next = {root[OUT_W-2:0], root_bit};
    assign accept    = i_valid && o_ready;
    assign last_iter = (cnt == '0);

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_nxt;
    end

    // Next-state and handshake outputs, decoded from the current state.
    always_comb begin
        state_nxt = state;
        o_ready   = 1'b0;
        o_valid   = 1'b0;
        o_busy    = 1'b0;
        case (state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) state_nxt = CALC;
            end
            CALC: begin
                o_busy = 1'b1;
`ifdef SQRT_FIXED_ROUND_EN
                if (last_iter) state_nxt = ROUND;
`else
                if (last_iter) state_nxt = DONE;
`endif
            end
`ifdef SQRT_FIXED_ROUND_EN
            ROUND: begin
                o_busy    = 1'b1;
                state_nxt = DONE;
            end
`endif
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: load on accept, iterate in CALC, capture the result on the last step.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            n_sr   <= '0;
            rem    <= '0;
            root   <= '0;
            cnt    <= '0;
            o_data <= '0;
            o_rem  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        n_sr <= N_W'(i_data) << FRAC_W;
                        rem  <= '0;
                        root <= '0;
                        cnt  <= CNT_W'(OUT_W - 1);
                    end
                end
                CALC: begin
                    n_sr <= n_sr << 2;
                    rem  <= rem_next;
                    root <= root_next;
                    cnt  <= cnt - 1'b1;
                    if (last_iter) begin
                        o_data <= root_next;
                        o_rem  <= (OUT_W+1)'(rem_next);
                    end
                end
`ifdef SQRT_FIXED_ROUND_EN
                ROUND: begin
                    // Round up when the remainder exceeds the root; all-ones cannot grow.
                    if ((rem > (OUT_W+2)'(root)) && !(&root)) o_data <= root + 1'b1;
                    else                                       o_data <= root;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_fixed_iter.sv
// Directed bench for sqrt_fixed_iter at DATA_W=16, FRAC_W=8 (OUT_W=12).
// Honours SQRT_FIXED_ROUND_EN for the expected latency and rounded roots.
module tb_sqrt_fixed_iter;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 8;
    localparam int OUT_W  = 12;
`ifdef SQRT_FIXED_ROUND_EN
    localparam int LAT      = 13;
    localparam bit ROUND_ON = 1'b1;
`else
    localparam int LAT      = 12;
    localparam bit ROUND_ON = 1'b0;
`endif

    // Clock and reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic              in_valid;
    logic              out_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              in_ready;
    logic [OUT_W-1:0]  out_data;
    logic [OUT_W:0]    out_rem;
    logic              busy;

    sqrt_fixed_iter #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) dut (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .i_valid   (in_valid),
        .o_ready   (out_ready),
        .i_data    (in_data),
        .o_valid   (out_valid),
        .i_ready   (in_ready),
        .o_data    (out_data),
        .o_rem     (out_rem),
        .o_busy    (busy)
    );

    // Scoreboard: {rem, root} per issued operand
    logic [2*OUT_W:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Driver: present an operand in IDLE and let the accept edge pass.
    task automatic issue(input logic [DATA_W-1:0] data, input logic [OUT_W-1:0] root_e,
                         input logic [OUT_W:0] rem_e, input string tag);
        int w;
        w = 0;
        while (!out_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_ready_before"}, 32'(out_ready), 32'd1);
        exp_q.push_back({rem_e, root_e});
        in_valid = 1'b1;
        in_data  = data;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = DATA_W'($urandom_range(0, 65535));
        check({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    // Wait for the result (bounded), compare latency and values to the scoreboard.
    task automatic wait_result(input string tag);
        int edges;
        logic [2*OUT_W:0] e;
        edges = 0;
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        e = exp_q.pop_front();
        check({tag, "_latency"}, 32'(edges), 32'(LAT));
        check({tag, "_root"}, 32'(out_data), 32'(e[OUT_W-1:0]));
        check({tag, "_rem"}, 32'(out_rem), 32'(e[2*OUT_W:OUT_W]));
    endtask

    task automatic consume(input string tag);
        in_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_ready = 1'b0;
        check({tag, "_valid_after"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_after"}, 32'(out_ready), 32'd1);
    endtask

    task automatic run_op(input logic [DATA_W-1:0] data, input logic [OUT_W-1:0] root_e,
                          input logic [OUT_W:0] rem_e, input string tag);
        issue(data, root_e, rem_e, tag);
        wait_result(tag);
        consume(tag);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_ready = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_data",  32'(out_data),  32'd0);
        check("rst_rem",   32'(out_rem),   32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(out_ready), 32'd1);

        // Directed roots
        run_op(16'h0400, 12'h200, 13'd0,    "four");
        run_op(16'h0200, 12'h16A, 13'd28,   "two");
        run_op(16'hFFFF, 12'hFFF, 13'd7935, "max");
        run_op(16'h0000, 12'h000, 13'd0,    "zero");
        run_op(16'h0001, 12'h010, 13'd0,    "lsb");
        run_op(16'h0A00, ROUND_ON ? 12'h32A : 12'h329, 13'd879, "ten");

        // Backpressure: hold DONE with i_valid toggling data
        issue(16'h0400, 12'h200, 13'd0, "bp");
        wait_result("bp");
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'($urandom_range(0, 65535));
            @(posedge clk);
            @(negedge clk);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_data",  32'(out_data),  32'h200);
            check("bp_hold_rem",   32'(out_rem),   32'd0);
            check("bp_hold_ready", 32'(out_ready), 32'd0);
        end
        in_data  = 16'h0100;
        in_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_ready = 1'b0;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(out_ready), 32'd1);
        exp_q.push_back({13'd0, 12'h100});
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_accept_busy", 32'(busy), 32'd1);
        wait_result("bp_next");
        consume("bp_next");

        // Reset during CALC aborts the operation
        in_valid = 1'b1;
        in_data  = 16'h0400;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("abort_busy_pre", 32'(busy), 32'd1);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_busy",  32'(busy),      32'd0);
        check("abort_ready", 32'(out_ready), 32'd1);
        repeat (15) @(posedge clk);
        @(negedge clk);
        check("abort_no_result", 32'(out_valid), 32'd0);
        run_op(16'h0400, 12'h200, 13'd0, "after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
